line_pos_counter: RTL

Parametrised loadable up/down position counter for the Wild Cube line-movement datapath, successor to the fixed 16-bit, fixed-bound vertical line mover. One instance drives one line coordinate (horizontal or vertical) between programmable lower and upper bounds. It supports a variable step size, saturate/wrap/bounce boundary modes, boundary-level flags and single-cycle boundary-hit pulses. It sits between the button/switch front end and the VGA line-drawing logic.

---
 rtl/line_pos_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/line_pos_counter.sv
// line_pos_counter: loadable up/down coordinate counter bounded to [LO, HI].
// Supports saturate (MODE 0), wrap (MODE 1) and bounce (MODE 2) behaviour at
// the bounds, plus level flags (at_hi/at_lo) and registered hit pulses.
//
// Handshake: there is no valid/ready pair. UP, DW and LD are plain per-cycle
// commands sampled on every rising edge; pos reflects them one edge later.
module line_pos_counter #(
   parameter int WIDTH  = 16,
   parameter int LO     = 18,
   parameter int HI     = 487,
   parameter int STEP_W = 4,
   parameter int MODE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              UP,
   input  logic              DW,
   input  logic              LD,
   input  logic [WIDTH-1:0]  d,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  pos,
   output logic              at_hi,
   output logic              at_lo,
   output logic              hit_hi,
   output logic              hit_lo,
   output logic              dir
);

   // Two spare bits: one for carry past HI, one for sign when going below zero.
   localparam int XW = WIDTH + 2;

   localparam logic [WIDTH-1:0]     LO_W  = WIDTH'(LO);
   localparam logic [WIDTH-1:0]     HI_W  = WIDTH'(HI);
   localparam logic signed [XW-1:0] LO_X  = XW'(LO);
   localparam logic signed [XW-1:0] HI_X  = XW'(HI);
   localparam logic signed [XW-1:0] ONE_X = XW'(1);

   // Bounce direction state; in modes 0/1 it never leaves UP_ST.
   typedef enum logic {
      UP_ST = 1'b0,
      DN_ST = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  pos_q, pos_d;
   logic              hit_hi_q, hit_hi_d;
   logic              hit_lo_q, hit_lo_d;

   logic signed [XW-1:0] pos_x;
   logic signed [XW-1:0] step_x;
   logic signed [XW-1:0] s_up;
   logic signed [XW-1:0] s_dn;
   logic signed [XW-1:0] s_mv;
   logic signed [XW-1:0] res_x;

   // Widened candidate positions for a move up and a move down.
   always_comb begin
      pos_x  = {2'b00, pos_q};
      step_x = {{(XW-STEP_W){1'b0}}, step};
      s_up   = pos_x + step_x;
      s_dn   = pos_x - step_x;
   end

   // Next-state logic: load beats move; boundary handling depends on MODE.
   always_comb begin
      pos_d   = pos_q;
      state_d = state_q;
      s_mv    = s_up;
      res_x   = pos_x;

      if (LD) begin
         if (d < LO_W) begin
            pos_d = LO_W;
         end else if (d > HI_W) begin
            pos_d = HI_W;
         end else begin
            pos_d = d;
         end
      end else if (MODE == 2) begin
         // Bounce: UP is a run enable, DW is ignored.
         if (UP && (step != '0)) begin
            if (state_q == UP_ST) begin
               if (s_up >= HI_X) begin
                  pos_d   = HI_W;
                  state_d = DN_ST;
               end else begin
                  pos_d = s_up[WIDTH-1:0];
               end
            end else begin
               if (s_dn <= LO_X) begin
                  pos_d   = LO_W;
                  state_d = UP_ST;
               end else begin
                  pos_d = s_dn[WIDTH-1:0];
               end
            end
         end
      end else if (UP != DW) begin
         s_mv = UP ? s_up : s_dn;
         if (s_mv > HI_X) begin
            res_x = (MODE == 1) ? (LO_X + (s_mv - HI_X - ONE_X)) : HI_X;
         end else if (s_mv < LO_X) begin
            res_x = (MODE == 1) ? (HI_X - (LO_X - s_mv - ONE_X)) : LO_X;
         end else begin
            res_x = s_mv;
         end
         pos_d = res_x[WIDTH-1:0];
      end

      // Pulse only on arrival at a bound, not while sitting on it.
      hit_hi_d = (pos_d == HI_W) && (pos_q != HI_W);
      hit_lo_d = (pos_d == LO_W) && (pos_q != LO_W);
   end

   // Register update with synchronous active-low reset overriding everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pos_q    <= LO_W;
         state_q  <= UP_ST;
         hit_hi_q <= 1'b0;
         hit_lo_q <= 1'b0;
      end else begin
         pos_q    <= pos_d;
         state_q  <= state_d;
         hit_hi_q <= hit_hi_d;
         hit_lo_q <= hit_lo_d;
      end
   end

   assign pos    = pos_q;
   assign dir    = state_q;
   assign hit_hi = hit_hi_q;
   assign hit_lo = hit_lo_q;
   assign at_hi  = (pos_q == HI_W);
   assign at_lo  = (pos_q == LO_W);

endmodule
